// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
// Module      : y86_pkg
// Description : Shared Y86-64 encodings and default pipeline-register widths.
// Revision    : 1.0 - initial release
// ============================================================================
package y86_pkg;

  // Status codes carried down the pipeline
  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  // Instruction codes used for bubble injection and halt detection
  localparam logic [3:0] ICODE_HALT = 4'h0;
  localparam logic [3:0] ICODE_NOP  = 4'h1;

  // "No register" ID at the default register-ID width
  localparam logic [3:0] RNONE = 4'hF;

  // Default widths
  localparam int DEF_WORD_W  = 64;
  localparam int DEF_REG_W   = 4;
  localparam int DEF_NUM_VAL = 2;
  localparam int DEF_NUM_DST = 2;
  localparam int DEF_CNT_W   = 16;

  // True when a status code indicates an exception
  function automatic logic is_exc(input logic [1:0] stat);
    return stat != STAT_AOK;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Event counter that sticks at its maximum value instead of
//               wrapping. Synchronous active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] c_max = '1;
  localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

  logic [CNT_W-1:0] r_count;

  // Count qualifying events, holding once the all-ones value is reached
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && (r_count != c_max)) begin
      r_count <= r_count + c_one;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Parametrised Y86-64 pipeline register with stall (hold),
//               bubble (NOP injection), optional freeze-on-exception and
//               saturating stall/bubble event counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
  import y86_pkg::*;
#(
  parameter int NUM_VAL       = DEF_NUM_VAL,
  parameter int WORD_W        = DEF_WORD_W,
  parameter int NUM_DST       = DEF_NUM_DST,
  parameter int REG_W         = DEF_REG_W,
  parameter int FREEZE_ON_EXC = 0,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       bubble,
  input  logic [1:0]                 in_stat,
  input  logic [3:0]                 in_icode,
  input  logic [NUM_VAL*WORD_W-1:0]  in_val,
  input  logic [NUM_DST*REG_W-1:0]   in_dst,
  output logic [1:0]                 out_stat,
  output logic [3:0]                 out_icode,
  output logic [NUM_VAL*WORD_W-1:0]  out_val,
  output logic [NUM_DST*REG_W-1:0]   out_dst,
  output logic                       out_valid,
  output logic                       frozen,
  output logic                       ctrl_err,
  output logic [CNT_W-1:0]           stall_cnt,
  output logic [CNT_W-1:0]           bubble_cnt
);

  // Every dst field of a bubble is RNONE, i.e. the whole vector is all ones
  localparam logic [NUM_DST*REG_W-1:0] c_dst_none = '1;
  localparam bit                       c_freeze   = (FREEZE_ON_EXC != 0);

  logic [1:0]                r_stat;
  logic [3:0]                r_icode;
  logic [NUM_VAL*WORD_W-1:0] r_val;
  logic [NUM_DST*REG_W-1:0]  r_dst;
  logic                      r_valid;
  logic                      r_frozen;
  logic                      r_ctrl_err;

  logic w_stall_inc;
  logic w_bubble_inc;

  // Stall wins over bubble, so a simultaneous request only counts as a stall
  assign w_stall_inc  = stall && !r_frozen;
  assign w_bubble_inc = bubble && !stall && !r_frozen;

  // Pipeline contents: reset > frozen > stall > bubble > load
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat     <= STAT_AOK;
      r_icode    <= ICODE_NOP;
      r_val      <= '0;
      r_dst      <= c_dst_none;
      r_valid    <= 1'b0;
      r_frozen   <= 1'b0;
      r_ctrl_err <= 1'b0;
    end else if (r_frozen) begin
      // Contents are parked on the faulting instruction until reset; no
      // control request is acted on, so none can be flagged as conflicting
      r_ctrl_err <= 1'b0;
    end else begin
      r_ctrl_err <= stall && bubble;
      if (stall) begin
        // hold current contents
      end else if (bubble) begin
        r_stat  <= STAT_AOK;
        r_icode <= ICODE_NOP;
        r_val   <= '0;
        r_dst   <= c_dst_none;
        r_valid <= 1'b0;
      end else begin
        r_stat  <= in_stat;
        r_icode <= in_icode;
        r_val   <= in_val;
        r_dst   <= in_dst;
        r_valid <= 1'b1;
        if (c_freeze && is_exc(in_stat)) begin
          r_frozen <= 1'b1;
        end
      end
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_bubble_inc),
    .count (bubble_cnt)
  );

  assign out_stat  = r_stat;
  assign out_icode = r_icode;
  assign out_val   = r_val;
  assign out_dst   = r_dst;
  assign out_valid = r_valid;
  assign frozen    = r_frozen;
  assign ctrl_err  = r_ctrl_err;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Self-checking bench for pipe_stage_reg. Two instances share
//               the same stimulus: A uses defaults, B uses FREEZE_ON_EXC=1
//               and CNT_W=2. Both are checked every cycle against a
//               behavioural model, plus literal spot checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         stall = 1'b0;
  logic         bubble = 1'b0;
  logic [1:0]   in_stat = 2'd0;
  logic [3:0]   in_icode = 4'd0;
  logic [127:0] in_val = '0;
  logic [7:0]   in_dst = '0;

  logic [1:0]   a_stat,  b_stat;
  logic [3:0]   a_icode, b_icode;
  logic [127:0] a_val,   b_val;
  logic [7:0]   a_dst,   b_dst;
  logic         a_valid, b_valid, a_frz, b_frz, a_cerr, b_cerr;
  logic [15:0]  a_sc, a_bc;
  logic [1:0]   b_sc, b_bc;

  int nvec = 0;
  int nerr = 0;

  // Model state, index 0 = instance A, 1 = instance B
  logic [1:0]  m_stat  [2];
  logic [3:0]  m_icode [2];
  logic [63:0] m_val   [2][2];
  logic [3:0]  m_dst   [2][2];
  logic        m_valid [2];
  logic        m_frz   [2];
  logic        m_cerr  [2];
  int          m_sc    [2];
  int          m_bc    [2];
  int          m_max   [2] = '{65535, 3};
  bit          m_fen   [2] = '{1'b0, 1'b1};

  always #5 clk = ~clk;

  pipe_stage_reg u_dut_a (
    .clk(clk), .rst(rst), .stall(stall), .bubble(bubble),
    .in_stat(in_stat), .in_icode(in_icode), .in_val(in_val), .in_dst(in_dst),
    .out_stat(a_stat), .out_icode(a_icode), .out_val(a_val), .out_dst(a_dst),
    .out_valid(a_valid), .frozen(a_frz), .ctrl_err(a_cerr),
    .stall_cnt(a_sc), .bubble_cnt(a_bc)
  );

  pipe_stage_reg #(.FREEZE_ON_EXC(1), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .stall(stall), .bubble(bubble),
    .in_stat(in_stat), .in_icode(in_icode), .in_val(in_val), .in_dst(in_dst),
    .out_stat(b_stat), .out_icode(b_icode), .out_val(b_val), .out_dst(b_dst),
    .out_valid(b_valid), .frozen(b_frz), .ctrl_err(b_cerr),
    .stall_cnt(b_sc), .bubble_cnt(b_bc)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Apply one edge's worth of the specification's rules to the model
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_stat[d] = 2'd0; m_icode[d] = 4'h1; m_valid[d] = 1'b0;
        for (int k = 0; k < 2; k++) begin m_val[d][k] = '0; m_dst[d][k] = 4'hF; end
        m_frz[d] = 1'b0; m_cerr[d] = 1'b0; m_sc[d] = 0; m_bc[d] = 0;
      end else if (m_frz[d]) begin
        m_cerr[d] = 1'b0;
      end else begin
        m_cerr[d] = stall && bubble;
        if (stall) begin
          if (m_sc[d] < m_max[d]) m_sc[d]++;
        end else if (bubble) begin
          if (m_bc[d] < m_max[d]) m_bc[d]++;
          m_stat[d] = 2'd0; m_icode[d] = 4'h1; m_valid[d] = 1'b0;
          for (int k = 0; k < 2; k++) begin m_val[d][k] = '0; m_dst[d][k] = 4'hF; end
        end else begin
          m_stat[d] = in_stat; m_icode[d] = in_icode; m_valid[d] = 1'b1;
          for (int k = 0; k < 2; k++) begin
            m_val[d][k] = in_val[k*64 +: 64];
            m_dst[d][k] = in_dst[k*4 +: 4];
          end
          if (m_fen[d] && in_stat != 2'd0) m_frz[d] = 1'b1;
        end
      end
    end
  endtask

  task automatic cmp_model();
    chk("a_stat", 128'(a_stat), 128'(m_stat[0]));
    chk("b_stat", 128'(b_stat), 128'(m_stat[1]));
    chk("a_icode", 128'(a_icode), 128'(m_icode[0]));
    chk("b_icode", 128'(b_icode), 128'(m_icode[1]));
    for (int k = 0; k < 2; k++) begin
      chk("a_val", 128'(a_val[k*64 +: 64]), 128'(m_val[0][k]));
      chk("b_val", 128'(b_val[k*64 +: 64]), 128'(m_val[1][k]));
      chk("a_dst", 128'(a_dst[k*4 +: 4]), 128'(m_dst[0][k]));
      chk("b_dst", 128'(b_dst[k*4 +: 4]), 128'(m_dst[1][k]));
    end
    chk("a_valid", 128'(a_valid), 128'(m_valid[0]));
    chk("b_valid", 128'(b_valid), 128'(m_valid[1]));
    chk("a_frozen", 128'(a_frz), 128'(m_frz[0]));
    chk("b_frozen", 128'(b_frz), 128'(m_frz[1]));
    chk("a_ctrl_err", 128'(a_cerr), 128'(m_cerr[0]));
    chk("b_ctrl_err", 128'(b_cerr), 128'(m_cerr[1]));
    chk("a_stall_cnt", 128'(a_sc), 128'(m_sc[0]));
    chk("b_stall_cnt", 128'(b_sc), 128'(m_sc[1]));
    chk("a_bubble_cnt", 128'(a_bc), 128'(m_bc[0]));
    chk("b_bubble_cnt", 128'(b_bc), 128'(m_bc[1]));
  endtask

  // Drive inputs at the falling edge, advance model at the rising edge,
  // and compare shortly after it
  task automatic step(input logic r, input logic s, input logic b,
                      input logic [1:0] st, input logic [3:0] ic,
                      input logic [127:0] v, input logic [7:0] ds);
    @(negedge clk);
    rst = r; stall = s; bubble = b;
    in_stat = st; in_icode = ic; in_val = v; in_dst = ds;
    @(posedge clk);
    model_edge();
    #1;
    cmp_model();
  endtask

  initial begin
    logic [127:0] v0;
    logic [1:0]   rs;

    // Reset then idle
    step(1, 0, 0, 2'd0, 4'h0, '0, '0);
    chk("rst_stat", 128'(a_stat), 128'h0);
    chk("rst_icode", 128'(a_icode), 128'h1);
    chk("rst_val", a_val, 128'h0);
    chk("rst_dst", 128'(a_dst), 128'hFF);
    chk("rst_valid", 128'(a_valid), 128'h0);
    chk("rst_cnt", 128'({a_sc, a_bc}), 128'h0);

    // Load
    v0 = {64'h5, 64'hA};
    step(0, 0, 0, 2'd0, 4'h6, v0, 8'h3F);
    chk("load_val", a_val, {64'h5, 64'hA});
    chk("load_dst", 128'(a_dst), 128'h3F);
    chk("load_icode", 128'(a_icode), 128'h6);
    chk("load_valid", 128'(a_valid), 128'h1);

    // Stall three cycles with changing inputs
    for (int i = 0; i < 3; i++) step(0, 1, 0, 2'd0, 4'(7 + i), 128'(i + 100), 8'(i));
    chk("stall_icode", 128'(a_icode), 128'h6);
    chk("stall_val", a_val, {64'h5, 64'hA});
    chk("stall_cnt3", 128'(a_sc), 128'd3);
    step(0, 0, 0, 2'd0, 4'h2, 128'h77, 8'h12);
    chk("release_icode", 128'(a_icode), 128'h2);

    // Stall and bubble together, then a clean load, then bubble alone
    step(0, 1, 1, 2'd0, 4'h9, 128'h99, 8'h45);
    chk("conflict_err", 128'(a_cerr), 128'h1);
    chk("conflict_icode", 128'(a_icode), 128'h2);
    chk("conflict_scnt", 128'(a_sc), 128'd4);
    chk("conflict_bcnt", 128'(a_bc), 128'd0);
    step(0, 0, 0, 2'd0, 4'h3, 128'h33, 8'h67);
    chk("err_pulse_end", 128'(a_cerr), 128'h0);
    step(0, 0, 1, 2'd0, 4'h3, 128'h33, 8'h67);
    chk("bubble_valid", 128'(a_valid), 128'h0);
    chk("bubble_icode", 128'(a_icode), 128'h1);
    chk("bubble_dst", 128'(a_dst), 128'hFF);
    chk("bubble_cnt1", 128'(a_bc), 128'd1);

    // Saturation of the 2-bit counters in instance B
    step(1, 0, 0, 2'd0, 4'h0, '0, '0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 2'd0, 4'h4, '0, '0);
    chk("sat_b_scnt", 128'(b_sc), 128'd3);
    chk("sat_a_scnt", 128'(a_sc), 128'd5);

    // Exception freeze in instance B
    step(0, 0, 0, 2'd2, 4'h5, 128'hDEAD, 8'h21);
    chk("frz_b", 128'(b_frz), 128'h1);
    chk("frz_a", 128'(a_frz), 128'h0);
    step(0, 0, 0, 2'd0, 4'h6, 128'h1, 8'h11);
    step(0, 0, 1, 2'd0, 4'h6, 128'h1, 8'h11);
    step(0, 1, 0, 2'd0, 4'h6, 128'h1, 8'h11);
    step(0, 1, 1, 2'd0, 4'h6, 128'h1, 8'h11);
    chk("frz_hold_stat", 128'(b_stat), 128'h2);
    chk("frz_hold_icode", 128'(b_icode), 128'h5);
    chk("frz_hold_val", b_val, 128'hDEAD);
    chk("frz_hold_cnt", 128'({b_sc, b_bc}), 128'hC);
    chk("frz_no_err", 128'(b_cerr), 128'h0);
    step(1, 0, 0, 2'd0, 4'h0, '0, '0);
    chk("frz_rst", 128'(b_frz), 128'h0);
    chk("frz_rst_icode", 128'(b_icode), 128'h1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rs = ($urandom_range(15) == 0) ? 2'($urandom_range(3, 1)) : 2'd0;
      step(($urandom_range(31) == 0), ($urandom_range(3) == 0), ($urandom_range(3) == 0),
           rs, 4'($urandom), {$urandom, $urandom, $urandom, $urandom}, 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
